// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: store-width codes understood by
// the data memory, its depth, the arbiter FSM state type and the packed request
// record used to mux the two requester ports onto the memory.
package data_memory_arbiter_pkg;

  // Store width codes (RISC-V funct3 encoding) forwarded untouched to the memory.
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // Data memory depth in 32-bit words.
  localparam int unsigned DATA_RAM_DEPTH = 256;

  // Address field is sized for the widest supported byte address; users truncate.
  localparam int unsigned MEM_ADDR_MAX_W = 32;

  typedef enum logic {
    CORE_PRIO = 1'b0,
    FORCE_DBG = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                      we;
    logic [MEM_ADDR_MAX_W-1:0] addr;
    logic [2:0]                func3;
    logic [31:0]               wdata;
  } mem_req_t;

endpackage

// File: rtl/data_memory_arbiter.sv
// Arbitrates the single-port data memory between the core load/store path (core_*)
// and the debug/program-loader path (dbg_*). The core has fixed priority; a
// starvation counter forces one debug grant after MAX_WAIT consecutive lost cycles.
// Load data is registered once and returned with a one-cycle rvalid to its owner.
//
// Ports:
//   clk, reset                      clock (rising edge), synchronous active-high reset
//   core_req/we/addr/func3/wdata    core request; core_gnt grant, core_rvalid/rdata return
//   dbg_req/we/addr/func3/wdata     debug request; dbg_gnt grant, dbg_rvalid/rdata return
//   mem_byte_address/store_func3/write_enable/write_data   memory drive
//   mem_read_data                   combinational read word from memory
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [2:0]        core_func3,
  input  logic [31:0]       core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [31:0]       core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [2:0]        dbg_func3,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic [ADDR_W-1:0] mem_byte_address,
  output logic [2:0]        mem_store_func3,
  output logic              mem_write_enable,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  localparam int unsigned     CntW   = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_WAIT);

  arb_state_t      state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            core_rvalid_q, core_rvalid_d;
  logic            dbg_rvalid_q, dbg_rvalid_d;

  logic     sel_dbg;
  logic     granted;
  mem_req_t core_pkt, dbg_pkt, sel_req;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= CORE_PRIO;
      wait_cnt_q    <= '0;
      rdata_q       <= '0;
      core_rvalid_q <= 1'b0;
      dbg_rvalid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      rdata_q       <= rdata_d;
      core_rvalid_q <= core_rvalid_d;
      dbg_rvalid_q  <= dbg_rvalid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      CORE_PRIO: begin
        if (dbg_req && !dbg_gnt) begin
          if (wait_cnt_q < MaxCnt) begin
            wait_cnt_d = wait_cnt_q + CntW'(1);
          end
          if (wait_cnt_d == MaxCnt) begin
            state_d = FORCE_DBG;
          end
        end else begin
          wait_cnt_d = '0;
        end
      end
      // Either the forced grant happens now or debug withdrew; both end the episode.
      FORCE_DBG: begin
        state_d    = CORE_PRIO;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = CORE_PRIO;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Outputs: grants, memory mux and load return
  always_comb begin
    core_pkt = '{we: core_we, addr: MEM_ADDR_MAX_W'(core_addr),
                 func3: core_func3, wdata: core_wdata};
    dbg_pkt  = '{we: dbg_we, addr: MEM_ADDR_MAX_W'(dbg_addr),
                 func3: dbg_func3, wdata: dbg_wdata};

    sel_dbg  = !reset && dbg_req && (!core_req || (state_q == FORCE_DBG));
    core_gnt = !reset && core_req && !sel_dbg;
    dbg_gnt  = sel_dbg;
    granted  = core_gnt || dbg_gnt;

    // With no grant the core port still drives address/func3/data.
    sel_req          = sel_dbg ? dbg_pkt : core_pkt;
    mem_byte_address = ADDR_W'(sel_req.addr);
    mem_store_func3  = sel_req.func3;
    mem_write_data   = sel_req.wdata;
    mem_write_enable = granted && sel_req.we && !reset;

    core_rvalid_d = core_gnt && !core_we;
    dbg_rvalid_d  = dbg_gnt && !dbg_we;
    rdata_d       = (granted && !sel_req.we) ? mem_read_data : rdata_q;

    // A return cycle that coincides with reset is suppressed.
    core_rvalid = core_rvalid_q && !reset;
    dbg_rvalid  = dbg_rvalid_q && !reset;
    core_rdata  = rdata_q;
    dbg_rdata   = rdata_q;
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
module tb_data_memory_arbiter;
  import data_memory_arbiter_pkg::*;

  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned ADDR_W   = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              core_req, core_we, dbg_req, dbg_we;
  logic [ADDR_W-1:0] core_addr, dbg_addr;
  logic [2:0]        core_func3, dbg_func3;
  logic [31:0]       core_wdata, dbg_wdata;
  logic              core_gnt, core_rvalid, dbg_gnt, dbg_rvalid;
  logic [31:0]       core_rdata, dbg_rdata;
  logic [ADDR_W-1:0] mem_byte_address;
  logic [2:0]        mem_store_func3;
  logic              mem_write_enable;
  logic [31:0]       mem_write_data;
  logic [31:0]       mem_read_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_memory_arbiter #(.MAX_WAIT(MAX_WAIT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_func3(core_func3), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_func3(dbg_func3), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_byte_address(mem_byte_address), .mem_store_func3(mem_store_func3),
    .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  // Byte-lane store into a 32-bit word; store data is already lane-positioned.
  function automatic logic [31:0] store_word(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [2:0] f3, input logic [1:0] a);
    logic [3:0]  m;
    logic [31:0] r;
    case (f3)
      F3_SB:   m = 4'b0001 << a;
      F3_SH:   m = 4'b0011 << {a[1], 1'b0};
      default: m = 4'b1111;
    endcase
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // Environment memory driven by the DUT
  logic [31:0] env_mem [DATA_RAM_DEPTH];
  logic        init_mem = 1'b1;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < int'(DATA_RAM_DEPTH); i++) env_mem[i] <= '0;
    end else if (mem_write_enable) begin
      env_mem[mem_byte_address[9:2]] <= store_word(env_mem[mem_byte_address[9:2]],
          mem_write_data, mem_store_func3, mem_byte_address[1:0]);
    end
  end
  assign mem_read_data = env_mem[mem_byte_address[9:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model and per-cycle compare (sampled on the falling edge)
  initial begin : cmp_proc
    logic [31:0] ref_mem [DATA_RAM_DEPTH];
    int          lost;
    logic        pend_core, pend_dbg, e_dbg, e_core, e_any, e_we;
    logic [31:0] e_rdata, e_wd;
    logic [ADDR_W-1:0] e_addr;
    logic [2:0]  e_f3;
    for (int i = 0; i < int'(DATA_RAM_DEPTH); i++) ref_mem[i] = '0;
    lost = 0; pend_core = 0; pend_dbg = 0; e_rdata = '0;
    forever begin
      @(negedge clk);
      e_dbg  = !reset && dbg_req && (!core_req || lost >= int'(MAX_WAIT));
      e_core = !reset && core_req && !e_dbg;
      e_any  = e_core || e_dbg;
      e_we   = e_dbg ? dbg_we : core_we;
      e_addr = e_dbg ? dbg_addr : core_addr;
      e_f3   = e_dbg ? dbg_func3 : core_func3;
      e_wd   = e_dbg ? dbg_wdata : core_wdata;
      chk("core_gnt", 32'(core_gnt), 32'(e_core));
      chk("dbg_gnt", 32'(dbg_gnt), 32'(e_dbg));
      chk("mem_we", 32'(mem_write_enable), 32'(e_any && e_we));
      chk("mem_addr", 32'(mem_byte_address), 32'(e_addr));
      if (e_any && e_we) begin
        chk("mem_func3", 32'(mem_store_func3), 32'(e_f3));
        chk("mem_wdata", mem_write_data, e_wd);
      end
      chk("core_rvalid", 32'(core_rvalid), 32'(pend_core && !reset));
      chk("dbg_rvalid", 32'(dbg_rvalid), 32'(pend_dbg && !reset));
      if (pend_core && !reset) chk("core_rdata", core_rdata, e_rdata);
      if (pend_dbg && !reset) chk("dbg_rdata", dbg_rdata, e_rdata);
      // advance model
      if (reset) begin
        lost = 0; pend_core = 0; pend_dbg = 0;
      end else begin
        if (dbg_req && !e_dbg) lost = (lost < int'(MAX_WAIT)) ? lost + 1 : lost;
        else lost = 0;
        pend_core = e_core && !e_we;
        pend_dbg  = e_dbg && !e_we;
        if (e_any && !e_we) e_rdata = ref_mem[e_addr[9:2]];
        if (e_any && e_we)
          ref_mem[e_addr[9:2]] = store_word(ref_mem[e_addr[9:2]], e_wd, e_f3, e_addr[1:0]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_req = 0; core_we = 0; core_addr = '0; core_func3 = F3_SW; core_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_func3 = F3_SW; dbg_wdata = '0;
  endtask

  function automatic logic [2:0] rnd_f3();
    case ($urandom_range(0, 2))
      0:       return F3_SB;
      1:       return F3_SH;
      default: return F3_SW;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    idle();
    cyc();
    init_mem = 1'b0;
    #2;
    chk("reset_core_rvalid", 32'(core_rvalid), 32'd0);
    chk("reset_state", 32'(dut.state_q), 32'(CORE_PRIO));
    cyc();

    // Core store then load
    reset = 0;
    core_req = 1; core_we = 1; core_addr = 10'h010; core_func3 = F3_SW;
    core_wdata = 32'hDEADBEEF;
    #2; chk("st_core_gnt", 32'(core_gnt), 32'd1);
    cyc(); core_we = 0;
    #2; chk("ld_core_gnt", 32'(core_gnt), 32'd1);
    cyc(); idle();
    #2; chk("ld_core_rvalid", 32'(core_rvalid), 32'd1);
    chk("ld_core_rdata", core_rdata, 32'hDEADBEEF);

    // Debug-only byte store then load
    cyc();
    dbg_req = 1; dbg_we = 1; dbg_addr = 10'h021; dbg_func3 = F3_SB; dbg_wdata = 32'h0000AB00;
    #2; chk("sb_dbg_gnt", 32'(dbg_gnt), 32'd1);
    cyc(); dbg_we = 0; dbg_addr = 10'h020;
    cyc(); idle();
    #2; chk("ld_dbg_rvalid", 32'(dbg_rvalid), 32'd1);
    chk("ld_dbg_rdata", dbg_rdata, 32'h0000AB00);
    chk("ld_dbg_core_rvalid", 32'(core_rvalid), 32'd0);

    // Starvation: both held, period 5
    cyc();
    core_req = 1; dbg_req = 1; core_addr = 10'h000; dbg_addr = 10'h004;
    for (int i = 0; i < 10; i++) begin
      #2;
      chk("starve_dbg_gnt", 32'(dbg_gnt), 32'((i % 5) == 4));
      chk("starve_core_gnt", 32'(core_gnt), 32'((i % 5) != 4));
      cyc();
    end

    // Simultaneous request with an empty counter
    idle();
    cyc();
    core_req = 1; dbg_req = 1;
    #2; chk("simul_core_gnt", 32'(core_gnt), 32'd1);
    chk("simul_dbg_gnt", 32'(dbg_gnt), 32'd0);
    cyc(); idle();
    #2; chk("simul_wait_cnt", 32'(dut.wait_cnt_q), 32'd1);

    // Debug withdraws while forced
    cyc();
    core_req = 1; dbg_req = 1;
    for (int i = 0; i < 4; i++) cyc();
    dbg_req = 0;
    #2; chk("drop_state_forced", 32'(dut.state_q), 32'(FORCE_DBG));
    chk("drop_core_gnt", 32'(core_gnt), 32'd1);
    chk("drop_dbg_gnt", 32'(dbg_gnt), 32'd0);
    cyc(); idle();
    #2; chk("drop_state", 32'(dut.state_q), 32'(CORE_PRIO));
    chk("drop_wait_cnt", 32'(dut.wait_cnt_q), 32'd0);

    // Reset after a granted load, with a core store pending during reset
    cyc();
    core_req = 1; core_we = 0; core_addr = 10'h010;
    #2; chk("rst_ld_gnt", 32'(core_gnt), 32'd1);
    cyc();
    reset = 1; core_we = 1; core_addr = 10'h040; core_func3 = F3_SW; core_wdata = 32'h12345678;
    #2; chk("rst_core_rvalid", 32'(core_rvalid), 32'd0);
    chk("rst_mem_we", 32'(mem_write_enable), 32'd0);
    cyc();
    reset = 0; idle();
    #2; chk("rst_post_rvalid", 32'(core_rvalid), 32'd0);
    chk("rst_post_state", 32'(dut.state_q), 32'(CORE_PRIO));
    chk("rst_mem_040", env_mem[10'h040 >> 2], 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc();
      reset      = ($urandom_range(0, 63) == 0);
      core_req   = ($urandom_range(0, 9) < 8);
      core_we    = $urandom_range(0, 1) == 1;
      core_addr  = ADDR_W'($urandom_range(0, 127));
      core_func3 = rnd_f3();
      core_wdata = $urandom;
      dbg_req    = ($urandom_range(0, 1) == 1);
      dbg_we     = $urandom_range(0, 1) == 1;
      dbg_addr   = ADDR_W'($urandom_range(0, 127));
      dbg_func3  = rnd_f3();
      dbg_wdata  = $urandom;
    end
    cyc();
    reset = 0; idle();
    cyc();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
